spark_tester_core: RTL and testbench
====================================

Name: spark_tester_core

Overview:
Single-clock Ethernet tester core for the spark system. It contains a register-programmable GMII traffic generator, a GMII traffic analyzer with 64-bit statistics counters, and a TX source mux. The core is reached over a simple word-addressed register bus. In system benches, port TX is looped back to RX.

Parameters:
TPL_WORDS, 32, depth of generator template memory in 32-bit words
IFG_RESET, 12, reset value of the generator interframe-gap register

Ports:
aclk  in  1  core and GMII clock (one byte per cycle)
areset  in  1  asynchronous, active-high reset
reg_wr  in  1  register write strobe (single cycle)
reg_rd  in  1  register read strobe (single cycle)
reg_addr  in  10  byte address; bits[1:0] are ignored
reg_wdata  in  32  write data
reg_rdata  out  32  read data
reg_ack  out  1  one-cycle acknowledge for each rd/wr strobe
ext_txd  in  8  external GMII TX data (mux passthrough)
ext_tx_en  in  1  external GMII TX enable
gmii_txd  out  8  GMII TX data
gmii_tx_en  out  1  GMII TX enable
gmii_rxd  in  8  GMII RX data
gmii_rx_dv  in  1  GMII RX data valid
gmii_rx_er  in  1  GMII RX error

Behaviour:
- Reset values: all outputs 0; registers at their listed resets; counters 0; template empty.
- Register bus
  - reg_ack is asserted the cycle after a strobe.
  - reg_rdata is valid with reg_ack and is 0 otherwise.
  - Unmapped addresses read 0 and ignore writes.
  - If reg_rd and reg_wr are asserted together, the write wins and the read returns 0.
- Generator registers (0x000-0x0FF)
  - 0x00 ID: RO, 0x54470001.
  - 0x0C FLIP: reads return the bitwise inverse of the last value written. Reset value is 0, so it reads 0xFFFFFFFF.
  - 0x10 CTRL: bit0 enable, bit1 continuous. Reset 0.
  - 0x14 IFG: idle cycles between frames. Reset IFG_RESET. A value of 0 is treated as 1.
  - 0x4C: any write clears the template (length 0).
  - 0x50: write appends a word to the template. Writes beyond TPL_WORDS are dropped.
  - 0x54: RO, template length in words.
- Generator FSM: IDLE -> SEND -> GAP -> (SEND | IDLE)
  - IDLE -> SEND when enable=1 and length>0.
  - SEND drives tx_en=1 and the template bytes, MSB byte of each word first, for 4*length cycles. The template includes preamble, SFD and FCS; nothing is appended.
  - GAP holds tx_en=0 for IFG cycles.
  - After GAP: go to SEND if enable=1 and continuous=1, otherwise IDLE. With continuous=0, each 0->1 transition of enable sends exactly one frame.
  - Clearing enable mid-frame finishes the current frame, then the FSM goes to IDLE. No runt frames are produced.
  - Template writes while not IDLE are accepted but take effect only from the next frame, because the length is latched at SEND entry.
- Mux register 0x208: bits[1:0], reset 0.
  - Value 3: gmii_txd/gmii_tx_en come from the generator.
  - Any other value: they come from ext_txd/ext_tx_en.
  - Outputs are registered, adding 1 cycle of latency.
  - 0x200 ID: RO, 0x4D580001.
- Analyzer registers (0x100-0x1FF)
  - 0x100 ID: RO, 0x54410001.
  - 0x10C FLIP: same behaviour as the generator FLIP.
  - 0x110 CTRL: bit0 enable, bit1 freeze.
  - 64-bit counters, hi word at the lower address:
    - PKTS 0x120/0x124
    - OCTETS 0x128/0x12C
    - OCTETS_IDLE 0x130/0x134
    - BAD_CRC_PKTS 0x158/0x15C
    - BAD_CRC_OCTETS 0x160/0x164
- Analyzer counting
  - Counting happens only while enable=1 and freeze=0.
  - OCTETS increments on every cycle with rx_dv=1, including preamble/SFD bytes.
  - OCTETS_IDLE increments on every cycle with rx_dv=0.
  - PKTS increments on each falling edge of rx_dv.
- Analyzer CRC check
  - CRC-32 (poly 0x04C11DB7, reflected, init 0xFFFFFFFF) runs over the bytes after the first 0xD5 byte up to the end of the frame.
  - The frame is good if the final register equals residue 0xDEBB20E3 (uncomplemented form, equivalent to 0xC704DD7B).
  - A frame is bad if the residue mismatches, no SFD was seen, or rx_er was high during the frame.
  - Each bad frame adds 1 to BAD_CRC_PKTS and its total length (including preamble) to BAD_CRC_OCTETS.
- Freeze
  - Freeze rising edge snapshots all counters; reads return the snapshot while freeze=1.
  - Live counters stop while frozen and resume from their values when freeze is cleared.
  - Writing CTRL with bit2=1 clears all counters; bit2 is self-clearing.
- Counters wrap at 2^64.
- areset mid-frame: tx_en drops asynchronously and the FSM returns to IDLE.

Test Plan:
- Reset, then read 0x000/0x100/0x200 -> 0x54470001/0x54410001/0x4D580001. All counters read 0 and FLIP reads 0xFFFFFFFF.
- Write 0x12345678 to 0x00C and 0x10C -> both read 0xEDCBA987.
- Loop TX to RX, mux=3, IFG=12, load 18-word valid frame (7x55, D5, 64 data bytes incl. FCS). Analyzer enable=1, generator CTRL=3 for 10 frames, CTRL=0, freeze -> PKTS=10, OCTETS=720, BAD_CRC_PKTS=0.
- Same frame with last word corrupted, single shot (CTRL=1) -> PKTS=1, BAD_CRC_PKTS=1, BAD_CRC_OCTETS=72.
- Clear enable mid-frame -> that frame completes all 72 bytes, then tx_en stays 0. A later read of PKTS is unchanged.
- Mux=0, drive ext_tx_en/ext_txd=0xAB -> gmii_txd=0xAB one cycle later. Freeze holds the counter snapshot while traffic continues.

Source files
------------

// File: rtl/spark_tester_core.sv
// spark_tester_core: GMII traffic generator, traffic analyzer with 64-bit
// statistics and a registered TX source mux, all behind a word-addressed
// register bus. Single clock domain (aclk), one GMII byte per cycle.
//
// Generator FSM
//   state | meaning
//   IDLE  | tx_en low, waiting for enable and a non-empty template
//   SEND  | streaming 4*len template bytes, MSB byte of each word first
//   GAP   | interframe gap, tx_en low for max(IFG,1) cycles
module spark_tester_core #(
    parameter int TPL_WORDS = 32,
    parameter int IFG_RESET = 12
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        reg_wr,
    input  logic        reg_rd,
    input  logic [9:0]  reg_addr,
    input  logic [31:0] reg_wdata,
    output logic [31:0] reg_rdata,
    output logic        reg_ack,
    input  logic [7:0]  ext_txd,
    input  logic        ext_tx_en,
    output logic [7:0]  gmii_txd,
    output logic        gmii_tx_en,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er
);

    localparam int TW = $clog2(TPL_WORDS);
    localparam int LW = $clog2(TPL_WORDS + 1);
    localparam int BW = LW + 2;
    localparam int PW = TW + 2;

    // word addresses (byte address >> 2)
    localparam logic [7:0] A_GEN_ID   = 8'h00;
    localparam logic [7:0] A_GEN_FLIP = 8'h03;
    localparam logic [7:0] A_GEN_CTRL = 8'h04;
    localparam logic [7:0] A_GEN_IFG  = 8'h05;
    localparam logic [7:0] A_TPL_CLR  = 8'h13;
    localparam logic [7:0] A_TPL_DATA = 8'h14;
    localparam logic [7:0] A_TPL_LEN  = 8'h15;
    localparam logic [7:0] A_ANA_ID   = 8'h40;
    localparam logic [7:0] A_ANA_FLIP = 8'h43;
    localparam logic [7:0] A_ANA_CTRL = 8'h44;
    localparam logic [7:0] A_PKTS_HI  = 8'h48;
    localparam logic [7:0] A_PKTS_LO  = 8'h49;
    localparam logic [7:0] A_OCT_HI   = 8'h4A;
    localparam logic [7:0] A_OCT_LO   = 8'h4B;
    localparam logic [7:0] A_IDLE_HI  = 8'h4C;
    localparam logic [7:0] A_IDLE_LO  = 8'h4D;
    localparam logic [7:0] A_BADP_HI  = 8'h56;
    localparam logic [7:0] A_BADP_LO  = 8'h57;
    localparam logic [7:0] A_BADO_HI  = 8'h58;
    localparam logic [7:0] A_BADO_LO  = 8'h59;
    localparam logic [7:0] A_MUX_ID   = 8'h80;
    localparam logic [7:0] A_MUX_SEL  = 8'h82;

    localparam logic [31:0] GEN_ID = 32'h5447_0001;
    localparam logic [31:0] ANA_ID = 32'h5441_0001;
    localparam logic [31:0] MUX_ID = 32'h4D58_0001;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;

    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;
    localparam logic [7:0]  SFD         = 8'hD5;

    localparam int C_PKTS = 0;
    localparam int C_OCT  = 1;
    localparam int C_IDLE = 2;
    localparam int C_BADP = 3;
    localparam int C_BADO = 4;
    localparam int NCNT   = 5;

    logic [7:0]    wa;
    logic          unused_addr_bits;

    logic [31:0]   gen_flip;
    logic [1:0]    gen_ctrl;
    logic [31:0]   gen_ifg;
    logic [LW-1:0] tpl_len;
    logic [31:0]   tpl_mem [TPL_WORDS];
    logic [1:0]    mux_sel;
    logic [31:0]   ana_flip;
    logic          ana_en;
    logic          ana_frz;

    logic          tpl_push;
    logic          ana_clr;
    logic          frz_rise;

    assign wa               = reg_addr[9:2];
    assign unused_addr_bits = &{1'b0, reg_addr[1:0]};

    assign tpl_push = reg_wr && (wa == A_TPL_DATA) && (tpl_len < LW'(TPL_WORDS));
    assign ana_clr  = reg_wr && (wa == A_ANA_CTRL) && reg_wdata[2];
    assign frz_rise = reg_wr && (wa == A_ANA_CTRL) && reg_wdata[1] && !ana_frz;

    // Configuration registers written from the bus.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gen_flip <= '0;
            gen_ctrl <= '0;
            gen_ifg  <= 32'(IFG_RESET);
            tpl_len  <= '0;
            mux_sel  <= '0;
            ana_flip <= '0;
            ana_en   <= 1'b0;
            ana_frz  <= 1'b0;
        end else if (reg_wr) begin
            case (wa)
                A_GEN_FLIP: gen_flip <= reg_wdata;
                A_GEN_CTRL: gen_ctrl <= reg_wdata[1:0];
                A_GEN_IFG:  gen_ifg  <= reg_wdata;
                A_TPL_CLR:  tpl_len  <= '0;
                A_TPL_DATA: if (tpl_push) tpl_len <= tpl_len + LW'(1);
                A_ANA_FLIP: ana_flip <= reg_wdata;
                A_ANA_CTRL: begin
                    ana_en  <= reg_wdata[0];
                    ana_frz <= reg_wdata[1];
                end
                A_MUX_SEL:  mux_sel  <= reg_wdata[1:0];
                default: ;
            endcase
        end
    end

    // Template storage; contents need no reset because tpl_len gates use.
    always_ff @(posedge aclk) begin
        if (tpl_push) tpl_mem[tpl_len[TW-1:0]] <= reg_wdata;
    end

    // ---------------------------------------------------------------- generator
    logic [1:0]    gen_state;
    logic [BW-1:0] bytes_left;
    logic [PW-1:0] byte_ptr;
    logic [31:0]   gap_left;
    logic          en_prev;
    logic          armed;
    logic          gen_en;
    logic          gen_cont;
    logic          en_rise;
    logic [31:0]   ifg_eff;
    logic          start_idle;
    logic          start_gap;
    logic [BW-1:0] frame_last;
    logic [31:0]   gen_word;
    logic [7:0]    gen_byte;
    logic          gen_tx_en;
    logic [7:0]    gen_txd;

    assign gen_en     = gen_ctrl[0];
    assign gen_cont   = gen_ctrl[1];
    assign en_rise    = gen_en && !en_prev;
    assign ifg_eff    = (gen_ifg == 32'd0) ? 32'd1 : gen_ifg;
    assign start_idle = gen_en && (tpl_len != '0) && (gen_cont || armed || en_rise);
    assign start_gap  = gen_en && gen_cont && (tpl_len != '0);
    assign frame_last = {tpl_len, 2'b00} - BW'(1);

    // Frame sequencer; the length is latched into bytes_left at SEND entry.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gen_state  <= ST_IDLE;
            bytes_left <= '0;
            byte_ptr   <= '0;
            gap_left   <= '0;
            en_prev    <= 1'b0;
            armed      <= 1'b0;
        end else begin
            en_prev <= gen_en;
            case (gen_state)
                ST_IDLE: begin
                    if (start_idle) begin
                        gen_state  <= ST_SEND;
                        byte_ptr   <= '0;
                        bytes_left <= frame_last;
                        armed      <= 1'b0;
                    end else if (en_rise) begin
                        armed <= 1'b1;
                    end
                end
                ST_SEND: begin
                    if (en_rise) armed <= 1'b1;
                    if (bytes_left == '0) begin
                        gen_state <= ST_GAP;
                        gap_left  <= ifg_eff - 32'd1;
                    end else begin
                        bytes_left <= bytes_left - BW'(1);
                        byte_ptr   <= byte_ptr + PW'(1);
                    end
                end
                ST_GAP: begin
                    if (en_rise) armed <= 1'b1;
                    if (gap_left == 32'd0) begin
                        if (start_gap) begin
                            gen_state  <= ST_SEND;
                            byte_ptr   <= '0;
                            bytes_left <= frame_last;
                            armed      <= 1'b0;
                        end else begin
                            gen_state <= ST_IDLE;
                        end
                    end else begin
                        gap_left <= gap_left - 32'd1;
                    end
                end
                default: gen_state <= ST_IDLE;
            endcase
        end
    end

    assign gen_word = tpl_mem[byte_ptr[PW-1:2]];

    // Byte lane select, most significant byte first.
    always_comb begin
        gen_byte = 8'h00;
        case (byte_ptr[1:0])
            2'd0: gen_byte = gen_word[31:24];
            2'd1: gen_byte = gen_word[23:16];
            2'd2: gen_byte = gen_word[15:8];
            2'd3: gen_byte = gen_word[7:0];
            default: gen_byte = 8'h00;
        endcase
    end

    assign gen_tx_en = (gen_state == ST_SEND);
    assign gen_txd   = gen_tx_en ? gen_byte : 8'h00;

    // Registered TX source mux; reset clears tx_en immediately.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            gmii_txd   <= 8'h00;
            gmii_tx_en <= 1'b0;
        end else if (mux_sel == 2'd3) begin
            gmii_txd   <= gen_txd;
            gmii_tx_en <= gen_tx_en;
        end else begin
            gmii_txd   <= ext_txd;
            gmii_tx_en <= ext_tx_en;
        end
    end

    // ---------------------------------------------------------------- analyzer
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ d[i]) ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return c;
    endfunction

    logic        rx_dv_q;
    logic        fr_sfd;
    logic        fr_err;
    logic [31:0] fr_len;
    logic [31:0] fr_crc;
    logic        frame_end;
    logic        frame_bad;

    // Per-frame tracking: length, SFD detection, rx_er and running CRC.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_dv_q <= 1'b0;
            fr_sfd  <= 1'b0;
            fr_err  <= 1'b0;
            fr_len  <= '0;
            fr_crc  <= '1;
        end else begin
            rx_dv_q <= gmii_rx_dv;
            if (gmii_rx_dv) begin
                if (!rx_dv_q) begin
                    fr_len <= 32'd1;
                    fr_err <= gmii_rx_er;
                    fr_sfd <= (gmii_rxd == SFD);
                    fr_crc <= '1;
                end else begin
                    fr_len <= fr_len + 32'd1;
                    if (gmii_rx_er) fr_err <= 1'b1;
                    if (fr_sfd) fr_crc <= crc32_byte(fr_crc, gmii_rxd);
                    else if (gmii_rxd == SFD) fr_sfd <= 1'b1;
                end
            end
        end
    end

    assign frame_end = rx_dv_q && !gmii_rx_dv;
    assign frame_bad = !fr_sfd || fr_err || (fr_crc != CRC_RESIDUE);

    logic [63:0] cnt_q  [NCNT];
    logic [63:0] cnt_n  [NCNT];
    logic [63:0] snap_q [NCNT];
    logic [63:0] cnt_rd [NCNT];

    // Next counter values; clear wins over counting.
    always_comb begin
        for (int i = 0; i < NCNT; i++) cnt_n[i] = cnt_q[i];
        if (ana_clr) begin
            for (int i = 0; i < NCNT; i++) cnt_n[i] = '0;
        end else if (ana_en && !ana_frz) begin
            if (gmii_rx_dv) cnt_n[C_OCT]  = cnt_q[C_OCT] + 64'd1;
            else            cnt_n[C_IDLE] = cnt_q[C_IDLE] + 64'd1;
            if (frame_end) begin
                cnt_n[C_PKTS] = cnt_q[C_PKTS] + 64'd1;
                if (frame_bad) begin
                    cnt_n[C_BADP] = cnt_q[C_BADP] + 64'd1;
                    cnt_n[C_BADO] = cnt_q[C_BADO] + {32'd0, fr_len};
                end
            end
        end
    end

    // Live counters plus the snapshot taken when freeze is raised.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i]  <= '0;
                snap_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCNT; i++) begin
                cnt_q[i] <= cnt_n[i];
                if (frz_rise || ana_clr) snap_q[i] <= cnt_n[i];
            end
        end
    end

    // Reads see the snapshot while frozen.
    always_comb begin
        for (int i = 0; i < NCNT; i++) cnt_rd[i] = ana_frz ? snap_q[i] : cnt_q[i];
    end

    // ---------------------------------------------------------------- read path
    logic [31:0] rd_val;

    // Read data decode; unmapped words return 0.
    always_comb begin
        rd_val = 32'd0;
        case (wa)
            A_GEN_ID:   rd_val = GEN_ID;
            A_GEN_FLIP: rd_val = ~gen_flip;
            A_GEN_CTRL: rd_val = {30'd0, gen_ctrl};
            A_GEN_IFG:  rd_val = gen_ifg;
            A_TPL_LEN:  rd_val = 32'(tpl_len);
            A_ANA_ID:   rd_val = ANA_ID;
            A_ANA_FLIP: rd_val = ~ana_flip;
            A_ANA_CTRL: rd_val = {30'd0, ana_frz, ana_en};
            A_PKTS_HI:  rd_val = cnt_rd[C_PKTS][63:32];
            A_PKTS_LO:  rd_val = cnt_rd[C_PKTS][31:0];
            A_OCT_HI:   rd_val = cnt_rd[C_OCT][63:32];
            A_OCT_LO:   rd_val = cnt_rd[C_OCT][31:0];
            A_IDLE_HI:  rd_val = cnt_rd[C_IDLE][63:32];
            A_IDLE_LO:  rd_val = cnt_rd[C_IDLE][31:0];
            A_BADP_HI:  rd_val = cnt_rd[C_BADP][63:32];
            A_BADP_LO:  rd_val = cnt_rd[C_BADP][31:0];
            A_BADO_HI:  rd_val = cnt_rd[C_BADO][63:32];
            A_BADO_LO:  rd_val = cnt_rd[C_BADO][31:0];
            A_MUX_ID:   rd_val = MUX_ID;
            A_MUX_SEL:  rd_val = {30'd0, mux_sel};
            default:    rd_val = 32'd0;
        endcase
    end

    // One-cycle ack; a write strobe suppresses read data.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            reg_ack   <= 1'b0;
            reg_rdata <= 32'd0;
        end else begin
            reg_ack   <= reg_rd || reg_wr;
            reg_rdata <= (reg_rd && !reg_wr) ? rd_val : 32'd0;
        end
    end

endmodule

// File: tb/tb_spark_tester_core.sv
// Directed bench for spark_tester_core with TX looped back to RX.
module tb_spark_tester_core;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        reg_wr = 1'b0;
    logic        reg_rd = 1'b0;
    logic [9:0]  reg_addr = '0;
    logic [31:0] reg_wdata = '0;
    logic [31:0] reg_rdata;
    logic        reg_ack;
    logic [7:0]  ext_txd = 8'h00;
    logic        ext_tx_en = 1'b0;
    logic [7:0]  gmii_txd;
    logic        gmii_tx_en;
    logic        rx_er = 1'b0;

    spark_tester_core #(.TPL_WORDS(32), .IFG_RESET(12)) dut (
        .aclk       (aclk),
        .areset     (areset),
        .reg_wr     (reg_wr),
        .reg_rd     (reg_rd),
        .reg_addr   (reg_addr),
        .reg_wdata  (reg_wdata),
        .reg_rdata  (reg_rdata),
        .reg_ack    (reg_ack),
        .ext_txd    (ext_txd),
        .ext_tx_en  (ext_tx_en),
        .gmii_txd   (gmii_txd),
        .gmii_tx_en (gmii_tx_en),
        .gmii_rxd   (gmii_txd),
        .gmii_rx_dv (gmii_tx_en),
        .gmii_rx_er (rx_er)
    );

    always #5 aclk = ~aclk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // TX burst monitor
    int rise_cnt = 0, fall_cnt = 0, cur_burst = 0, last_burst = 0, cur_gap = 0, last_gap = 0;
    bit prev_en = 1'b0;
    always @(negedge aclk) begin
        if (gmii_tx_en) begin
            if (!prev_en) begin
                rise_cnt++;
                last_gap  = cur_gap;
                cur_burst = 0;
            end
            cur_burst++;
        end else begin
            if (prev_en) begin
                fall_cnt++;
                last_burst = cur_burst;
                cur_gap    = 0;
            end
            cur_gap++;
        end
        prev_en = gmii_tx_en;
    end

    task automatic bus_wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge aclk);
        reg_addr = a; reg_wdata = d; reg_wr = 1'b1;
        @(negedge aclk);
        reg_wr = 1'b0;
    endtask

    task automatic bus_rd(input logic [9:0] a, output logic [31:0] d);
        @(negedge aclk);
        reg_addr = a; reg_rd = 1'b1;
        @(negedge aclk);
        reg_rd = 1'b0;
        d = reg_rdata;
        check("rd_ack", {63'd0, reg_ack}, 64'd1);
    endtask

    task automatic rd64(input logic [9:0] a_hi, output logic [63:0] v);
        logic [31:0] hi, lo;
        bus_rd(a_hi, hi);
        bus_rd(a_hi + 10'd4, lo);
        v = {hi, lo};
    endtask

    task automatic wait_rises(input int target, input string what);
        int n = 0;
        while (rise_cnt < target && n < 3000) begin @(posedge aclk); n++; end
        check(what, {63'd0, rise_cnt >= target}, 64'd1);
    endtask

    task automatic wait_falls(input int target, input string what);
        int n = 0;
        while (fall_cnt < target && n < 3000) begin @(posedge aclk); n++; end
        check(what, {63'd0, fall_cnt >= target}, 64'd1);
    endtask

    // Reference frame: 7x55, D5, 60 payload bytes, 4 FCS bytes
    logic [7:0]  frm [72];
    logic [31:0] tpl [18];

    function automatic logic [31:0] ref_crc(input logic [31:0] c_in, input logic [7:0] d);
        logic [31:0] c;
        c = c_in ^ {24'd0, d};
        for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        return c;
    endfunction

    task automatic build_frame();
        logic [31:0] c;
        for (int i = 0; i < 7; i++) frm[i] = 8'h55;
        frm[7] = 8'hD5;
        for (int i = 0; i < 60; i++) frm[8 + i] = 8'(i * 13 + 1);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 60; i++) c = ref_crc(c, frm[8 + i]);
        c = ~c;
        frm[68] = c[7:0]; frm[69] = c[15:8]; frm[70] = c[23:16]; frm[71] = c[31:24];
        for (int w = 0; w < 18; w++)
            tpl[w] = {frm[4*w], frm[4*w + 1], frm[4*w + 2], frm[4*w + 3]};
    endtask

    task automatic load_template(input bit corrupt);
        bus_wr(10'h04C, 32'd0);
        for (int w = 0; w < 18; w++)
            bus_wr(10'h050, (corrupt && w == 17) ? (tpl[w] ^ 32'h1) : tpl[w]);
    endtask

    typedef struct {
        bit          wr;
        logic [9:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [32];
    int   n_vec = 0;

    task automatic add_vec(input bit wr, input logic [9:0] a, input logic [31:0] d, input logic [31:0] e);
        vecs[n_vec] = '{wr, a, d, e};
        n_vec++;
    endtask

    initial begin
        logic [31:0] r;
        logic [63:0] v;
        int base;

        build_frame();

        // reset-state reads and register behaviour
        add_vec(0, 10'h000, 0, 32'h54470001);
        add_vec(0, 10'h003, 0, 32'h54470001);
        add_vec(0, 10'h100, 0, 32'h54410001);
        add_vec(0, 10'h200, 0, 32'h4D580001);
        add_vec(0, 10'h00C, 0, 32'hFFFFFFFF);
        add_vec(0, 10'h10C, 0, 32'hFFFFFFFF);
        add_vec(0, 10'h010, 0, 32'h0);
        add_vec(0, 10'h014, 0, 32'd12);
        add_vec(0, 10'h054, 0, 32'h0);
        add_vec(0, 10'h110, 0, 32'h0);
        add_vec(0, 10'h124, 0, 32'h0);
        add_vec(0, 10'h12C, 0, 32'h0);
        add_vec(0, 10'h15C, 0, 32'h0);
        add_vec(0, 10'h164, 0, 32'h0);
        add_vec(0, 10'h208, 0, 32'h0);
        add_vec(1, 10'h00C, 32'h12345678, 0);
        add_vec(1, 10'h10C, 32'h12345678, 0);
        add_vec(0, 10'h00C, 0, 32'hEDCBA987);
        add_vec(0, 10'h10C, 0, 32'hEDCBA987);
        add_vec(1, 10'h3F0, 32'hDEADBEEF, 0);
        add_vec(0, 10'h3F0, 0, 32'h0);
        add_vec(1, 10'h000, 32'hFFFFFFFF, 0);
        add_vec(0, 10'h000, 0, 32'h54470001);
        add_vec(1, 10'h208, 32'h7, 0);
        add_vec(0, 10'h208, 0, 32'h3);
        add_vec(1, 10'h208, 32'h0, 0);
        add_vec(1, 10'h110, 32'h7, 0);
        add_vec(0, 10'h110, 0, 32'h3);
        add_vec(1, 10'h110, 32'h0, 0);

        repeat (3) @(negedge aclk);
        areset = 1'b0;
        check("reset_ack", {63'd0, reg_ack}, 64'd0);
        check("reset_tx_en", {63'd0, gmii_tx_en}, 64'd0);

        for (int i = 0; i < n_vec; i++) begin
            if (vecs[i].wr) begin
                bus_wr(vecs[i].addr, vecs[i].data);
            end else begin
                bus_rd(vecs[i].addr, r);
                check($sformatf("vec[%0d] rd 0x%0h", i, vecs[i].addr), {32'd0, r}, {32'd0, vecs[i].exp});
            end
        end

        // simultaneous rd+wr: write wins, read data 0, ack one cycle
        @(negedge aclk);
        reg_addr = 10'h014; reg_wdata = 32'd7; reg_wr = 1'b1; reg_rd = 1'b1;
        @(negedge aclk);
        reg_wr = 1'b0; reg_rd = 1'b0;
        check("rdwr_ack", {63'd0, reg_ack}, 64'd1);
        check("rdwr_rdata", {32'd0, reg_rdata}, 64'd0);
        @(negedge aclk);
        check("ack_one_cycle", {63'd0, reg_ack}, 64'd0);
        bus_rd(10'h014, r);
        check("rdwr_write_took", {32'd0, r}, 64'd7);
        bus_wr(10'h014, 32'd12);

        // idle octets: enabled for exactly 21 counting edges before freeze
        bus_wr(10'h110, 32'h1);
        repeat (20) @(posedge aclk);
        bus_wr(10'h110, 32'h3);
        rd64(10'h130, v);
        check("octets_idle", v, 64'd21);

        // template overflow and clear
        bus_wr(10'h04C, 32'd0);
        for (int i = 0; i < 33; i++) bus_wr(10'h050, 32'(i));
        bus_rd(10'h054, r);
        check("tpl_len_full", {32'd0, r}, 64'd32);
        bus_wr(10'h04C, 32'd0);
        bus_rd(10'h054, r);
        check("tpl_len_cleared", {32'd0, r}, 64'd0);

        // 10 continuous good frames through loopback
        load_template(1'b0);
        bus_rd(10'h054, r);
        check("tpl_len_18", {32'd0, r}, 64'd18);
        bus_wr(10'h014, 32'd12);
        bus_wr(10'h208, 32'd3);
        bus_wr(10'h110, 32'h5);
        base = rise_cnt;
        bus_wr(10'h010, 32'h3);
        wait_rises(base + 10, "wait_10_frames");
        bus_wr(10'h010, 32'h0);
        wait_falls(base + 10, "wait_10_ends");
        repeat (40) @(posedge aclk);
        check("cont_frames", 64'(rise_cnt - base), 64'd10);
        check("cont_burst_len", 64'(last_burst), 64'd72);
        check("cont_ifg", 64'(last_gap), 64'd12);
        bus_wr(10'h110, 32'h3);
        rd64(10'h120, v); check("pkts_10", v, 64'd10);
        rd64(10'h128, v); check("octets_720", v, 64'd720);
        rd64(10'h158, v); check("bad_pkts_0", v, 64'd0);
        rd64(10'h160, v); check("bad_oct_0", v, 64'd0);

        // single shot with corrupted FCS
        bus_wr(10'h110, 32'h5);
        load_template(1'b1);
        base = rise_cnt;
        bus_wr(10'h010, 32'h1);
        wait_rises(base + 1, "wait_bad_frame");
        wait_falls(base + 1, "wait_bad_end");
        repeat (150) @(posedge aclk);
        check("single_shot_once", 64'(rise_cnt - base), 64'd1);
        rd64(10'h120, v); check("bad_run_pkts", v, 64'd1);
        rd64(10'h128, v); check("bad_run_octets", v, 64'd72);
        rd64(10'h158, v); check("bad_crc_pkts", v, 64'd1);
        rd64(10'h160, v); check("bad_crc_octets", v, 64'd72);

        // IFG=0 acts as 1; clearing enable mid-frame finishes the frame
        bus_wr(10'h010, 32'h0);
        load_template(1'b0);
        bus_wr(10'h014, 32'd0);
        bus_wr(10'h110, 32'h5);
        base = rise_cnt;
        bus_wr(10'h010, 32'h3);
        wait_rises(base + 2, "wait_ifg0_frames");
        check("ifg0_gap", 64'(last_gap), 64'd1);
        repeat (10) @(posedge aclk);
        bus_wr(10'h010, 32'h0);
        wait_falls(base + 2, "wait_mid_end");
        check("mid_burst_len", 64'(last_burst), 64'd72);
        repeat (100) @(posedge aclk);
        check("mid_no_more", 64'(rise_cnt - base), 64'd2);
        rd64(10'h120, v); check("mid_pkts", v, 64'd2);
        repeat (50) @(posedge aclk);
        rd64(10'h120, v); check("mid_pkts_later", v, 64'd2);
        rd64(10'h158, v); check("mid_bad_pkts", v, 64'd0);

        // external passthrough, freeze holds snapshot while traffic runs
        bus_wr(10'h208, 32'h0);
        bus_wr(10'h110, 32'h3);
        @(negedge aclk);
        ext_txd = 8'hAB; ext_tx_en = 1'b1;
        #1;
        check("mux_latency_en", {63'd0, gmii_tx_en}, 64'd0);
        @(negedge aclk);
        check("mux_txd", {56'd0, gmii_txd}, 64'hAB);
        check("mux_tx_en", {63'd0, gmii_tx_en}, 64'd1);
        repeat (4) @(negedge aclk);
        ext_tx_en = 1'b0; ext_txd = 8'h00;
        repeat (5) @(negedge aclk);
        rd64(10'h120, v); check("frozen_pkts", v, 64'd2);
        rd64(10'h158, v); check("frozen_bad", v, 64'd0);
        bus_wr(10'h110, 32'h1);
        rd64(10'h120, v); check("resume_pkts", v, 64'd2);
        @(negedge aclk);
        ext_txd = 8'hAB; ext_tx_en = 1'b1;
        repeat (5) @(negedge aclk);
        ext_tx_en = 1'b0; ext_txd = 8'h00;
        repeat (5) @(negedge aclk);
        rd64(10'h120, v); check("ext_pkts", v, 64'd3);
        rd64(10'h158, v); check("ext_nosfd_bad", v, 64'd1);
        rd64(10'h160, v); check("ext_bad_oct", v, 64'd5);

        // asynchronous reset in the middle of a frame
        bus_wr(10'h014, 32'd12);
        bus_wr(10'h208, 32'h3);
        base = rise_cnt;
        bus_wr(10'h010, 32'h1);
        wait_rises(base + 1, "wait_rst_frame");
        repeat (5) @(posedge aclk);
        #2 areset = 1'b1;
        #1;
        check("areset_tx_en", {63'd0, gmii_tx_en}, 64'd0);
        @(negedge aclk);
        @(negedge aclk);
        areset = 1'b0;
        bus_rd(10'h054, r); check("post_rst_tpl_len", {32'd0, r}, 64'd0);
        bus_rd(10'h010, r); check("post_rst_ctrl", {32'd0, r}, 64'd0);
        repeat (50) @(posedge aclk);
        check("post_rst_idle", 64'(rise_cnt - base), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
